// File: rtl/mc_control.sv
// mc_control: multi-cycle RV32I control FSM (fetch/decode/exec/mem/wb/trap)
// in: clk reset inst mem_ack branch_taken; out: mem/regfile/alu/pc enables, trap, cause, retire
module mc_control #(
  parameter bit RV32E       = 1'b0,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst,
  input  logic        mem_ack,
  input  logic        branch_taken,
  output logic        mem_req,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        alu_src,
  output logic [3:0]  alu_op,
  output logic [1:0]  mem_to_reg,
  output logic [1:0]  jump,
  output logic [1:0]  pc_src,
  output logic        trap,
  output logic [1:0]  cause,
  output logic        retire
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(MEM_TIMEOUT);

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] C_ILL = 2'b01;
  localparam logic [1:0] C_BUS = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [1:0]    cause_q;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign f7  = inst[31:25];

  // Only the top bit of each register index matters for the RV32E check.
  logic unused_bits;
  assign unused_bits = ^{inst[23:20], inst[18:15], inst[10:7]};

  logic is_op, is_opi, is_ld, is_st, is_br;
  logic is_jal, is_jalr, is_lui, is_auipc;
  assign is_op    = opc == 7'b0110011;
  assign is_opi   = opc == 7'b0010011;
  assign is_ld    = opc == 7'b0000011;
  assign is_st    = opc == 7'b0100011;
  assign is_br    = opc == 7'b1100011;
  assign is_jal   = opc == 7'b1101111;
  assign is_jalr  = opc == 7'b1100111;
  assign is_lui   = opc == 7'b0110111;
  assign is_auipc = opc == 7'b0010111;

  logic f7_zero, f7_alt;
  assign f7_zero = f7 == 7'b0000000;
  assign f7_alt  = f7 == 7'b0100000;

  logic f_ok, use_rd, use_rs1, use_rs2;

  always_comb begin
    f_ok    = 1'b0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    unique case (1'b1)
      is_op: begin
        f_ok = f7_zero |
               (f7_alt & (f3 == 3'b000 | f3 == 3'b101));
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      is_opi: begin
        if (f3 == 3'b001)      f_ok = f7_zero;
        else if (f3 == 3'b101) f_ok = f7_zero | f7_alt;
        else                   f_ok = 1'b1;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
      end
      is_ld: begin
        f_ok = (f3 != 3'b011) & (f3[2:1] != 2'b11);
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
      end
      is_st: begin
        f_ok = ~f3[2] & (f3[1:0] != 2'b11);
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      is_br: begin
        f_ok = f3[2:1] != 2'b01;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      is_jalr: begin
        f_ok = f3 == 3'b000;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
      end
      is_jal, is_lui, is_auipc: begin
        f_ok   = 1'b1;
        use_rd = 1'b1;
      end
      default: f_ok = 1'b0;
    endcase
  end

  logic e_bad, legal;
  assign e_bad = RV32E & ((use_rd  & inst[11]) |
                          (use_rs1 & inst[19]) |
                          (use_rs2 & inst[24]));
  assign legal = f_ok & ~e_bad;

  // Immediate forms never subtract: bit 30 of an OP-IMM imm is just data.
  logic [3:0] alu_fn;
  always_comb begin
    alu_fn = ALU_ADD;
    unique case (f3)
      3'b000: alu_fn = (is_op & f7[5]) ? ALU_SUB : ALU_ADD;
      3'b001: alu_fn = ALU_SLL;
      3'b010: alu_fn = ALU_SLT;
      3'b011: alu_fn = ALU_SLTU;
      3'b100: alu_fn = ALU_XOR;
      3'b101: alu_fn = f7[5] ? ALU_SRA : ALU_SRL;
      3'b110: alu_fn = ALU_OR;
      3'b111: alu_fn = ALU_AND;
      default: alu_fn = ALU_ADD;
    endcase
  end

  logic       alu_src_d;
  logic [3:0] alu_op_d;
  always_comb begin
    alu_src_d = ~(is_op | is_br);
    alu_op_d  = ALU_ADD;
    unique case (1'b1)
      is_op, is_opi: alu_op_d = alu_fn;
      is_br: begin
        if (!f3[2])     alu_op_d = ALU_SUB;
        else if (!f3[1]) alu_op_d = ALU_SLT;
        else            alu_op_d = ALU_SLTU;
      end
      is_lui:  alu_op_d = ALU_PASSB;
      default: alu_op_d = ALU_ADD;
    endcase
  end

  logic tmo;
  assign tmo = timer == TMAX;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_FETCH;
      timer   <= '0;
      cause_q <= '0;
    end else begin
      timer <= '0;
      unique case (state)
        S_FETCH: begin
          if (mem_ack) begin
            state <= S_DECODE;
          end else if (tmo) begin
            state   <= S_TRAP;
            cause_q <= C_BUS;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DECODE: begin
          if (legal) begin
            state <= S_EXEC;
          end else begin
            state   <= S_TRAP;
            cause_q <= C_ILL;
          end
        end
        S_EXEC: begin
          if (is_br)              state <= S_FETCH;
          else if (is_ld | is_st) state <= S_MEM;
          else                    state <= S_WB;
        end
        S_MEM: begin
          if (mem_ack) begin
            state <= is_ld ? S_WB : S_FETCH;
          end else if (tmo) begin
            state   <= S_TRAP;
            cause_q <= C_BUS;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_WB:    state <= S_FETCH;
        S_TRAP:  state <= S_FETCH;
        default: state <= S_FETCH;
      endcase
    end
  end

  assign cause = cause_q;

  // Request drops only on the timeout cycle when no ack arrived.
  logic req_on;
  assign req_on = ~(tmo & ~mem_ack);

  always_comb begin
    mem_req    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    mem_to_reg = 2'b00;
    jump       = 2'b00;
    pc_src     = 2'b00;
    trap       = 1'b0;
    retire     = 1'b0;
    if (!reset) begin
      unique case (state)
        S_FETCH: begin
          mem_req  = req_on;
          mem_read = req_on;
          ir_write = mem_ack;
          pc_write = mem_ack;
        end
        S_EXEC: begin
          alu_src = alu_src_d;
          alu_op  = alu_op_d;
          if (is_br) begin
            jump     = 2'b01;
            pc_write = branch_taken;
            pc_src   = 2'b01;
            retire   = 1'b1;
          end else if (is_jal | is_jalr) begin
            jump     = 2'b11;
            pc_write = 1'b1;
            pc_src   = 2'b01;
          end
        end
        S_MEM: begin
          // ALU controls held so the address stays valid.
          alu_src   = alu_src_d;
          alu_op    = alu_op_d;
          mem_req   = req_on;
          mem_read  = req_on & is_ld;
          mem_write = req_on & is_st;
          retire    = mem_ack & is_st;
        end
        S_WB: begin
          alu_src   = alu_src_d;
          alu_op    = alu_op_d;
          reg_write = 1'b1;
          retire    = 1'b1;
          if (is_ld)                 mem_to_reg = 2'b01;
          else if (is_jal | is_jalr) mem_to_reg = 2'b10;
          else                       mem_to_reg = 2'b00;
        end
        S_TRAP: begin
          trap     = 1'b1;
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed bench for mc_control
// walks each instruction class, traps, timeout and reset mid-access
module tb_mc_control;

  logic        clk;
  logic        reset;
  logic [31:0] inst;
  logic        mem_ack;
  logic        branch_taken;
  logic        mem_req, mem_read, mem_write;
  logic        ir_write, pc_write, reg_write;
  logic        alu_src;
  logic [3:0]  alu_op;
  logic [1:0]  mem_to_reg, jump, pc_src;
  logic        trap;
  logic [1:0]  cause;
  logic        retire;

  mc_control #(
    .RV32E(1'b1),
    .MEM_TIMEOUT(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .inst(inst),
    .mem_ack(mem_ack),
    .branch_taken(branch_taken),
    .mem_req(mem_req),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .ir_write(ir_write),
    .pc_write(pc_write),
    .reg_write(reg_write),
    .alu_src(alu_src),
    .alu_op(alu_op),
    .mem_to_reg(mem_to_reg),
    .jump(jump),
    .pc_src(pc_src),
    .trap(trap),
    .cause(cause),
    .retire(retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [18:0] outs;
  assign outs = {mem_req, mem_read, mem_write, ir_write,
                 pc_write, reg_write, alu_src, alu_op,
                 mem_to_reg, jump, pc_src, trap, retire};

  localparam logic [31:0] ADDI  = 32'h00500093;
  localparam logic [31:0] SUB   = 32'h402081B3;
  localparam logic [31:0] SRAI  = 32'h4030D093;
  localparam logic [31:0] LUI   = 32'h123450B7;
  localparam logic [31:0] LW    = 32'h0000A103;
  localparam logic [31:0] SW    = 32'h0020A023;
  localparam logic [31:0] BEQ   = 32'h00208063;
  localparam logic [31:0] JAL   = 32'h000000EF;

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic a, input logic b);
    @(negedge clk);
    mem_ack      = a;
    branch_taken = b;
    #1;
  endtask

  // Fetch with immediate ack; also proves the prior instruction ended.
  task automatic fetch(input logic [31:0] i);
    @(negedge clk);
    inst         = i;
    mem_ack      = 1'b1;
    branch_taken = 1'b0;
    #1;
    chk("fetch", {mem_req, mem_read, ir_write,
                  pc_write, pc_src, trap}, 7'b1111000);
  endtask

  logic [31:0] at_i [4];
  logic [4:0]  at_e [4];
  logic [31:0] ill  [3];

  initial begin
    at_i = '{ADDI, SUB, SRAI, LUI};
    at_e = '{5'b1_0000, 5'b0_0001, 5'b1_0111, 5'b1_1010};
    ill  = '{32'h0000007F, 32'h00208833, 32'h02208133};

    reset        = 1'b1;
    inst         = '0;
    mem_ack      = 1'b0;
    branch_taken = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_outs", outs, 0);
    chk("rst_cause", cause, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel_req", {mem_req, mem_read, ir_write}, 3'b110);

    for (int k = 0; k < 4; k++) begin
      fetch(at_i[k]);
      cyc(0, 0);
      chk("alu_d", outs, 0);
      cyc(0, 0);
      chk("alu_e", {alu_src, alu_op, reg_write, retire},
          {at_e[k], 2'b00});
      cyc(0, 0);
      chk("alu_w", {reg_write, retire, mem_to_reg,
                    alu_src, alu_op}, {4'b1100, at_e[k]});
    end

    fetch(LW);
    cyc(0, 0);
    cyc(0, 0);
    chk("lw_e", {alu_src, alu_op, mem_req}, 6'b100000);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0);
      chk("lw_wait", {mem_req, mem_read, mem_write, retire},
          4'b1100);
    end
    cyc(1, 0);
    chk("lw_ack", {mem_req, mem_read, reg_write}, 3'b110);
    cyc(0, 0);
    chk("lw_wb", {reg_write, mem_to_reg, retire}, 4'b1011);

    fetch(SW);
    cyc(0, 0);
    cyc(0, 0);
    cyc(1, 0);
    chk("sw_mem", {mem_req, mem_read, mem_write,
                   retire, reg_write}, 5'b10110);

    for (int k = 0; k < 2; k++) begin
      fetch(BEQ);
      cyc(0, 0);
      cyc(0, k == 0);
      chk("beq_e", {pc_write, pc_src, jump, retire,
                    alu_src, alu_op},
          {(k == 0), 2'b01, 2'b01, 1'b1, 1'b0, 4'd1});
    end

    fetch(JAL);
    cyc(0, 0);
    cyc(0, 0);
    chk("jal_e", {jump, pc_write, pc_src, alu_op, alu_src},
        {2'b11, 1'b1, 2'b01, 4'd0, 1'b1});
    cyc(0, 0);
    chk("jal_w", {reg_write, mem_to_reg, retire}, 4'b1101);

    for (int k = 0; k < 3; k++) begin
      fetch(ill[k]);
      cyc(0, 0);
      chk("ill_d", outs, 0);
      cyc(0, 0);
      chk("ill_t", {trap, pc_write, pc_src, retire, reg_write},
          6'b111000);
      chk("ill_cause", cause, 2'b01);
    end

    for (int i = 0; i < 15; i++) begin
      cyc(0, 0);
      chk("to_wait", {mem_req, mem_read, trap}, 3'b110);
    end
    cyc(0, 0);
    chk("to_drop", {mem_req, mem_read, ir_write, trap}, 4'b0000);
    cyc(0, 0);
    chk("to_trap", {trap, pc_write, pc_src, retire}, 5'b11100);
    chk("to_cause", cause, 2'b10);

    for (int i = 0; i < 15; i++) begin
      cyc(0, 0);
      chk("a15_wait", {mem_req, trap}, 2'b10);
    end
    fetch(ADDI);
    cyc(0, 0);
    chk("a15_d", {outs, cause}, {19'd0, 2'b10});
    cyc(0, 0);
    cyc(0, 0);
    chk("a15_w", {reg_write, retire}, 2'b11);

    fetch(LW);
    cyc(0, 0);
    cyc(0, 0);
    cyc(0, 0);
    cyc(0, 0);
    chk("rm_mem", {mem_req, mem_read}, 2'b11);
    #2;
    reset = 1'b1;
    #1;
    chk("rm_outs", outs, 0);
    chk("rm_cause", cause, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rm_fetch", {mem_req, mem_read, mem_write, cause},
        5'b11000);
    for (int i = 0; i < 14; i++) begin
      cyc(0, 0);
      chk("rm_wait", mem_req, 1'b1);
    end
    cyc(0, 0);
    chk("rm_drop", mem_req, 1'b0);
    cyc(0, 0);
    chk("rm_trap", {trap, cause}, 3'b110);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control unit for the basic RV32I datapath. It replaces single-cycle combinational decoding with a state machine that sequences each instruction through fetch, decode, execute, memory and writeback. It issues memory requests through a req/ack handshake with a bounded wait. It traps on illegal encodings and on bus timeouts. Parameters select RV32I or RV32E register-index checking and set the memory timeout; the block sits in ID and drives every datapath enable.

## Interface
- `RV32E`, 0 — 1: rs1/rs2/rd index with bit 4 set is illegal.
- `MEM_TIMEOUT`, 15 — max cycles waiting for `mem_ack` before trap; ≥1.
- `clk` in 1 — clock.
- `reset` in 1 — asynchronous, active-high reset.
- `inst` in 32 — IR contents; held stable by datapath after `ir_write`.
- `mem_ack` in 1 — memory handshake completion.
- `branch_taken` in 1 — ALU compare result, valid in EXEC.
- `mem_req` out 1 — memory request, held until ack or timeout.
- `mem_read`, `mem_write` out 1 — access direction qualifiers for `mem_req`.
- `ir_write`, `pc_write`, `reg_write` out 1 — datapath register enables.
- `alu_src` out 1 — 0 rs2, 1 immediate.
- `alu_op` out 4 — 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
- `mem_to_reg` out 2 — 00 ALU, 01 memory, 10 PC+4.
- `jump` out 2 — 00 none, 01 branch, 11 jal/jalr.
- `pc_src` out 2 — 00 PC+4, 01 ALU target, 10 trap vector.
- `trap` out 1 — one-cycle pulse.
- `cause` out 2 — 01 illegal, 10 bus timeout; held until the next trap or reset.
- `retire` out 1 — one-cycle pulse when an instruction completes.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Exit from reset: FETCH.
- Outputs are decoded from state plus `inst`. Any output not listed for a state is 0.
- **FETCH**
  - Drives `mem_req`=1 and `mem_read`=1.
  - On `mem_ack`: `ir_write`=1, `pc_write`=1, `pc_src`=00, go to DECODE.
- **DECODE**
  - Classifies the opcode: OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
  - Any other opcode, bad funct3/funct7, or an RV32E index violation goes to TRAP with `cause`=01.
  - Valid instructions go to EXEC.
  - funct7 check:
    - OP requires 0000000, except SUB/SRA which require 0100000.
    - SLLI/SRLI require 0000000; SRAI requires 0100000.
- **EXEC**
  - `alu_src`=1 for all except OP and BRANCH.
  - OP/OP-IMM: `alu_op` from funct3/funct7; go to WB.
  - LOAD/STORE: ADD; go to MEM.
  - LUI: PASSB; go to WB.
  - AUIPC: ADD; go to WB.
  - BRANCH:
    - `jump`=01; `alu_op` = SUB for BEQ/BNE, SLT for BLT/BGE, SLTU for BLTU/BGEU.
    - `pc_write`=`branch_taken`, `pc_src`=01.
    - `retire`=1, then FETCH.
  - JAL/JALR: `jump`=11, ADD, `pc_write`=1, `pc_src`=01; go to WB.
- **MEM**
  - `mem_req`=1, plus `mem_read` (LOAD) or `mem_write` (STORE).
  - On ack:
    - LOAD goes to WB.
    - STORE asserts `retire` and goes to FETCH.
- **WB**
  - `reg_write`=1, `retire`=1, then FETCH.
  - `mem_to_reg`: 01 for LOAD, 10 for JAL/JALR, 00 otherwise.
  - rd=0 still asserts `reg_write`; the register file ignores x0.
- **TRAP**
  - `trap`=1, `pc_write`=1, `pc_src`=10, then FETCH. No retire.
- **Wait timer**
  - Width $clog2(MEM_TIMEOUT+1). Cleared on entry to FETCH or MEM; increments each waiting cycle.
  - At count MEM_TIMEOUT without ack: `mem_req` drops, go to TRAP with `cause`=10.
  - Ack in the same cycle the count reaches MEM_TIMEOUT: ack wins, no trap.
- `mem_ack` outside FETCH/MEM is ignored.

## Timing
- While `reset`=1 all outputs are forced to 0, including `cause`. State=FETCH and timer=0 asynchronously.
- Reset mid-access abandons the request; `mem_req` is low while reset is asserted.
- Minimum cycles per instruction:
  - BRANCH 3
  - ALU, LUI, AUIPC, JAL, JALR 4
  - STORE 4
  - LOAD 5
- Each memory wait cycle adds one cycle.
- `ir_write`, `pc_write`, `trap` and `retire` are single-cycle pulses; `mem_req` is a level.
- `cause` updates in the TRAP cycle.

## Test plan
- `addi x1,x0,5` (0x00500093), ack in 1st FETCH cycle → states F,D,E,W. In WB: `reg_write`=1, `alu_src`=1, `alu_op`=0, `retire`=1; 4 cycles total.
- `lw x2,0(x1)` with ack delayed 3 cycles in MEM → MEM held 3 cycles with `mem_read`=1. Then WB with `mem_to_reg`=01; 8 cycles total.
- `beq` with `branch_taken`=1, then with 0 → EXEC `pc_write` 1 and 0 respectively, `pc_src`=01, `jump`=01. Back to FETCH after 3 cycles.
- Opcode 0x7F, then `add x16,x1,x2` with RV32E=1 → `trap` pulse, `cause`=01, `pc_src`=10, no `retire`.
- No ack with MEM_TIMEOUT=15 → 15 waiting cycles, then TRAP with `cause`=10. A separate run with ack exactly at count 15 → DECODE, no trap.
- Reset asserted in the middle of a MEM wait → all outputs 0 immediately. After release, FETCH with `mem_req`=1 and timer=0.
